// File: rtl/ram_phase_arbiter.sv
// Shares one RAM socket between video (phi_0 low), CPU (phi_0 high) and a DMA requester
// that may take the phi_0-high slot. Everything is registered on clk_14M.
module ram_phase_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 2,
    parameter int DMA_ENABLE  = 1
) (
    input  logic              clk_14M,
    input  logic              reset,
    input  logic              phi_0,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw_n,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_valid,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rw_n,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              overrun
);

    // state    | meaning
    // IDLE     | after reset, waiting for the first phi_0 edge
    // VID_WAIT | video read in flight
    // CPU_WAIT | CPU access in flight
    // DMA_WAIT | DMA access in flight
    // HOLD     | slot finished, waiting for the next edge
    typedef enum logic [2:0] {IDLE, VID_WAIT, CPU_WAIT, DMA_WAIT, HOLD} state_t;

    localparam logic [2:0] LAT = 3'(RAM_LATENCY);

    state_t            state_q;
    logic              phi_prev_q;
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_d;
    logic              rd_q;
    logic [DATA_W-1:0] vid_data_q, cpu_rdata_q, dma_rdata_q, ram_wdata_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              vid_valid_q, cpu_valid_q, dma_valid_q;
    logic              ram_en_q, ram_we_q, dma_gnt_q, cpu_stall_q, overrun_q;
    logic              fall, rise, in_wait, dma_take;

    assign fall     = phi_prev_q & ~phi_0;
    assign rise     = ~phi_prev_q & phi_0;
    assign in_wait  = (state_q == VID_WAIT) || (state_q == CPU_WAIT) || (state_q == DMA_WAIT);
    assign dma_take = dma_req && (DMA_ENABLE != 0);
    assign cnt_d    = cnt_q - 3'd1;

    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phi_prev_q  <= 1'b0;
            cnt_q       <= 3'd0;
            rd_q        <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            ram_wdata_q <= '0;
            ram_addr_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            dma_gnt_q   <= 1'b0;
            cpu_stall_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            phi_prev_q  <= phi_0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
            if (fall) begin
                if (in_wait) overrun_q <= 1'b1;
                ram_addr_q  <= vid_addr;
                ram_en_q    <= 1'b1;
                rd_q        <= 1'b1;
                cnt_q       <= LAT;
                dma_gnt_q   <= 1'b0;
                cpu_stall_q <= 1'b0;
                state_q     <= VID_WAIT;
            end else if (rise) begin
                if (in_wait) overrun_q <= 1'b1;
                ram_en_q <= 1'b1;
                cnt_q    <= LAT;
                if (dma_take) begin
                    ram_addr_q  <= dma_addr;
                    ram_we_q    <= ~dma_rw_n;
                    ram_wdata_q <= dma_wdata;
                    rd_q        <= dma_rw_n;
                    dma_gnt_q   <= 1'b1;
                    cpu_stall_q <= 1'b1;
                    state_q     <= DMA_WAIT;
                end else begin
                    ram_addr_q  <= cpu_addr;
                    ram_we_q    <= ~cpu_rw_n;
                    ram_wdata_q <= cpu_wdata;
                    rd_q        <= cpu_rw_n;
                    dma_gnt_q   <= 1'b0;
                    cpu_stall_q <= 1'b0;
                    state_q     <= CPU_WAIT;
                end
            end else if (in_wait) begin
                // counter reaching zero on this tick is the capture point
                if (cnt_q == 3'd1) begin
                    state_q <= HOLD;
                    cnt_q   <= 3'd0;
                    if (rd_q) begin
                        case (state_q)
                            VID_WAIT: begin vid_data_q  <= ram_rdata; vid_valid_q <= 1'b1; end
                            CPU_WAIT: begin cpu_rdata_q <= ram_rdata; cpu_valid_q <= 1'b1; end
                            default:  begin dma_rdata_q <= ram_rdata; dma_valid_q <= 1'b1; end
                        endcase
                    end
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_valid = cpu_valid_q;
    assign cpu_stall = cpu_stall_q;
    assign dma_gnt   = dma_gnt_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_valid = dma_valid_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ram_phase_arbiter.sv
// Scoreboard bench for ram_phase_arbiter: each phi_0 edge pushes the expected RAM strobe and read
// result; the monitor pops and compares them as the DUT produces them. A second instance uses latency 4.
module tb_ram_phase_arbiter;

    localparam int LAT = 2;

    logic        clk_14M = 1'b0;
    logic        reset;
    logic        phi_0, phi4;
    logic [15:0] vid_addr, cpu_addr, dma_addr;
    logic        cpu_rw_n, dma_rw_n, dma_req;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic [7:0]  vid_data, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
    logic        vid_valid, cpu_valid, cpu_stall, dma_gnt, dma_valid, ram_en, ram_we, overrun;
    logic [15:0] ram_addr;

    logic [7:0]  vid_data4, cpu_rdata4, dma_rdata4, ram_wdata4;
    logic        vid_valid4, cpu_valid4, cpu_stall4, dma_gnt4, dma_valid4, ram_en4, ram_we4, overrun4;
    logic [15:0] ram_addr4;
    logic [7:0]  ram_rdata4;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_cpu4 = 0;
    int n_vid4 = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
        int          tick;
    } ram_item_t;

    typedef struct {
        logic [2:0]  src;
        logic [7:0]  data;
        int          tick;
    } rd_item_t;

    ram_item_t ram_exp[$];
    rd_item_t  rd_exp[$];

    always #35 clk_14M = ~clk_14M;
    always @(posedge clk_14M) cyc <= cyc + 1;

    ram_phase_arbiter dut (
        .clk_14M(clk_14M), .reset(reset), .phi_0(phi_0),
        .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_addr(cpu_addr), .cpu_rw_n(cpu_rw_n), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rw_n(dma_rw_n), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_valid(dma_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .overrun(overrun)
    );

    ram_phase_arbiter #(.RAM_LATENCY(4)) u_lat4 (
        .clk_14M(clk_14M), .reset(reset), .phi_0(phi4),
        .vid_addr(vid_addr), .vid_data(vid_data4), .vid_valid(vid_valid4),
        .cpu_addr(cpu_addr), .cpu_rw_n(cpu_rw_n), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata4), .cpu_valid(cpu_valid4), .cpu_stall(cpu_stall4),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rw_n(dma_rw_n), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt4), .dma_rdata(dma_rdata4), .dma_valid(dma_valid4),
        .ram_addr(ram_addr4), .ram_wdata(ram_wdata4), .ram_en(ram_en4), .ram_we(ram_we4),
        .ram_rdata(ram_rdata4), .overrun(overrun4)
    );

    function automatic logic [7:0] ram_f(input logic [15:0] a);
        return (a == 16'h0400) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    // RAM model: read data is only valid on the tick after the strobe, garbage otherwise
    logic        en_d1;
    logic [15:0] addr_d1;
    always @(posedge clk_14M) begin
        en_d1   <= ram_en & ~ram_we;
        addr_d1 <= ram_addr;
    end
    assign ram_rdata  = en_d1 ? ram_f(addr_d1) : 8'hEE;
    assign ram_rdata4 = 8'h3C;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk_14M);
            #1;
        end
    endtask

    // Drive a phi_0 change and push what the slot must produce; capt=0 when the read will be dropped
    task automatic set_phi(input logic lvl, input bit capt);
        ram_item_t r;
        rd_item_t  d;
        bit        rd;
        phi_0  = lvl;
        r.tick = cyc + 1;
        if (!lvl) begin
            r.addr = vid_addr; r.we = 1'b0; r.wd = 8'h00; rd = 1'b1; d.src = 3'b001;
        end else if (dma_req) begin
            r.addr = dma_addr; r.we = ~dma_rw_n; r.wd = dma_wdata; rd = dma_rw_n; d.src = 3'b100;
        end else begin
            r.addr = cpu_addr; r.we = ~cpu_rw_n; r.wd = cpu_wdata; rd = cpu_rw_n; d.src = 3'b010;
        end
        ram_exp.push_back(r);
        if (rd && capt) begin
            d.data = ram_f(r.addr);
            d.tick = cyc + 1 + LAT;
            rd_exp.push_back(d);
        end
    endtask

    ram_item_t  mr;
    rd_item_t   md;
    logic [7:0] mdata;
    always @(negedge clk_14M) begin
        if (!reset) begin
            if (ram_en) begin
                if (ram_exp.size() == 0) begin
                    chk("ram_en_unexpected", 32'd1, 32'd0);
                end else begin
                    mr = ram_exp.pop_front();
                    chk("ram_addr", 32'(ram_addr), 32'(mr.addr));
                    chk("ram_we", 32'(ram_we), 32'(mr.we));
                    if (mr.we) chk("ram_wdata", 32'(ram_wdata), 32'(mr.wd));
                    chk("ram_tick", cyc, mr.tick);
                end
            end else if (ram_we) begin
                chk("ram_we_idle", 32'(ram_we), 32'd0);
            end
            if (vid_valid || cpu_valid || dma_valid) begin
                if (rd_exp.size() == 0) begin
                    chk("valid_unexpected", 32'({dma_valid, cpu_valid, vid_valid}), 32'd0);
                end else begin
                    md = rd_exp.pop_front();
                    chk("rd_src", 32'({dma_valid, cpu_valid, vid_valid}), 32'(md.src));
                    mdata = md.src[0] ? vid_data : (md.src[1] ? cpu_rdata : dma_rdata);
                    chk("rd_data", 32'(mdata), 32'(md.data));
                    chk("rd_tick", cyc, md.tick);
                end
            end
        end
        if (cpu_valid4) n_cpu4++;
        if (vid_valid4) n_vid4++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; phi_0 = 1'b0; phi4 = 1'b0;
        vid_addr = 16'h0000; cpu_addr = 16'h1111; cpu_rw_n = 1'b1; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_addr = 16'h0000; dma_rw_n = 1'b1; dma_wdata = 8'h00;
        ticks(3);
        reset = 1'b0;
        ticks(2);

        // reset in the middle of a CPU read: strobe happens, capture must not
        set_phi(1'b1, 1'b0);
        ticks(2);
        reset = 1'b1;
        phi_0 = 1'b0;
        #1;
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_gnt_stall", 32'({dma_gnt, cpu_stall}), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        ticks(2);
        reset = 1'b0;
        ticks(5);
        chk("post_rst_ram_en", 32'(ram_en), 32'd0);
        chk("post_rst_valids", 32'({vid_valid, cpu_valid, dma_valid}), 32'd0);

        // standard 7/7 phases, video read of 0400 returns A5
        vid_addr = 16'h0400; cpu_addr = 16'h1234; cpu_rw_n = 1'b1;
        set_phi(1'b1, 1'b1); ticks(7);
        set_phi(1'b0, 1'b1); ticks(7);
        chk("vid_data_a5", 32'(vid_data), 32'hA5);
        chk("cpu_rdata_1234", 32'(cpu_rdata), 32'(ram_f(16'h1234)));

        // CPU write
        cpu_rw_n = 1'b0; cpu_addr = 16'hC000; cpu_wdata = 8'h5A; vid_addr = 16'h0401;
        set_phi(1'b1, 1'b1); ticks(7);
        chk("cpu_rdata_held", 32'(cpu_rdata), 32'(ram_f(16'h1234)));
        set_phi(1'b0, 1'b1); ticks(7);

        // DMA read steals the slot; dropping dma_req mid-phase keeps the grant
        cpu_rw_n = 1'b1; cpu_addr = 16'h3000;
        dma_req = 1'b1; dma_addr = 16'h2000; dma_rw_n = 1'b1;
        set_phi(1'b1, 1'b1); ticks(1);
        chk("dma_gnt_on", 32'(dma_gnt), 32'd1);
        chk("cpu_stall_on", 32'(cpu_stall), 32'd1);
        ticks(3);
        dma_req = 1'b0;
        ticks(3);
        chk("dma_gnt_hold", 32'(dma_gnt), 32'd1);
        chk("cpu_stall_hold", 32'(cpu_stall), 32'd1);
        set_phi(1'b0, 1'b1);
        chk("dma_gnt_pre_fall", 32'(dma_gnt), 32'd1);
        ticks(1);
        chk("dma_gnt_off", 32'(dma_gnt), 32'd0);
        chk("cpu_stall_off", 32'(cpu_stall), 32'd0);
        ticks(6);
        chk("dma_rdata", 32'(dma_rdata), 32'(ram_f(16'h2000)));

        // dma_req one tick late: CPU keeps this slot, DMA (write) gets the next one
        set_phi(1'b1, 1'b1); ticks(1);
        dma_req = 1'b1; dma_rw_n = 1'b0; dma_addr = 16'h2468; dma_wdata = 8'hC3;
        chk("late_req_no_gnt", 32'(dma_gnt), 32'd0);
        ticks(6);
        chk("late_req_no_stall", 32'(cpu_stall), 32'd0);
        set_phi(1'b0, 1'b1); ticks(7);
        set_phi(1'b1, 1'b1); ticks(1);
        chk("next_rise_gnt", 32'(dma_gnt), 32'd1);
        dma_req = 1'b0;
        ticks(6);
        set_phi(1'b0, 1'b1); ticks(7);
        chk("overrun_clear", 32'(overrun), 32'd0);

        // latency-4 instance: normal cycle, then a 3-tick high phase that overruns
        cpu_rw_n = 1'b1; dma_req = 1'b0;
        phi4 = 1'b1; ticks(7);
        phi4 = 1'b0; ticks(7);
        chk("lat4_cpu_valid", n_cpu4, 1);
        chk("lat4_vid_valid", n_vid4, 1);
        chk("lat4_cpu_rdata", 32'(cpu_rdata4), 32'h3C);
        chk("lat4_overrun_0", 32'(overrun4), 32'd0);
        phi4 = 1'b1; ticks(3);
        phi4 = 1'b0; ticks(7);
        chk("lat4_short_no_cpu", n_cpu4, 1);
        chk("lat4_short_vid", n_vid4, 2);
        chk("lat4_overrun_1", 32'(overrun4), 32'd1);
        phi4 = 1'b1; ticks(7);
        phi4 = 1'b0; ticks(7);
        chk("lat4_overrun_sticky", 32'(overrun4), 32'd1);
        chk("lat4_cpu_after", n_cpu4, 2);

        chk("ram_q_empty", ram_exp.size(), 0);
        chk("rd_q_empty", rd_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
